// File: rtl/fifo_drain_rr_arb_if.sv
// fifo_drain_rr_arb_if: source-FIFO drain bus and output stream of the round-robin drain arbiter.
interface fifo_drain_rr_arb_if #(
    parameter int N_SRC      = 4,
    parameter int FIFO_WIDTH = 8
);
    localparam int ID_W = $clog2(N_SRC);
    logic                        arb_en;
    logic [N_SRC-1:0]            src_empty;
    logic [N_SRC*FIFO_WIDTH-1:0] src_data;
    logic [N_SRC-1:0]            src_read_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [FIFO_WIDTH-1:0]       out_data;
    logic [ID_W-1:0]             out_src_id;
    logic                        out_last;
    logic                        busy;
    modport master (
        input  arb_en, src_empty, src_data, out_ready,
        output src_read_en, out_valid, out_data, out_src_id, out_last, busy
    );
    modport slave (
        output arb_en, src_empty, src_data, out_ready,
        input  src_read_en, out_valid, out_data, out_src_id, out_last, busy
    );
endinterface

// File: rtl/fifo_drain_rr_arb.sv
// fifo_drain_rr_arb: round-robin drain of N_SRC FIFOs into one registered valid/ready stream.
module fifo_drain_rr_arb #(
    parameter int N_SRC      = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fifo_drain_rr_arb_if.master    bus
);
    localparam int ID_W = $clog2(N_SRC);
    localparam int BW   = $clog2(MAX_BURST);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]            r_state;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_last_grant;
    logic [BW-1:0]         r_beat;
    logic                  r_out_valid;
    logic [FIFO_WIDTH-1:0] r_out_data;
    logic [ID_W-1:0]       r_out_src_id;
    logic                  r_out_last;
    logic [ID_W-1:0]       w_next_grant;
    logic [FIFO_WIDTH-1:0] w_word;
    logic                  w_load;
    logic                  w_last_beat;
    logic                  w_any;

    // Scan from the far end so the nearest non-empty source after last_grant wins.
    always_comb begin : next_grant
        logic [ID_W-1:0] idx;
        idx = '0;
        w_next_grant = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            idx = ID_W'((int'(r_last_grant) + i) % N_SRC);
            if (!bus.src_empty[idx]) w_next_grant = idx;
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_SRC; i++)
            if (r_grant == ID_W'(i)) w_word = bus.src_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end

    assign w_any       = |(~bus.src_empty);
    assign w_last_beat = r_beat == BW'(MAX_BURST - 1);
    assign w_load      = (r_state == ST_BURST) && !bus.src_empty[r_grant] && (!r_out_valid || bus.out_ready);

    assign bus.src_read_en = w_load ? ({{(N_SRC-1){1'b0}}, 1'b1} << r_grant) : '0;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_src_id  = r_out_src_id;
    assign bus.out_last    = r_out_last;
    assign bus.busy        = (r_state == ST_BURST) || r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(N_SRC - 1);
            r_beat       <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src_id <= '0;
            r_out_last   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_data   <= w_word;
                r_out_src_id <= r_grant;
                r_out_valid  <= 1'b1;
                r_out_last   <= w_last_beat;
                r_beat       <= r_beat + BW'(1);
            end else if (bus.out_ready) begin
                r_out_valid  <= 1'b0;
            end
            if (r_state == ST_IDLE) begin
                if (bus.arb_en && w_any) begin
                    r_grant <= w_next_grant;
                    r_beat  <= '0;
                    r_state <= ST_BURST;
                end
            end else if ((w_load && w_last_beat) || bus.src_empty[r_grant]) begin
                r_state      <= ST_IDLE;
                r_last_grant <= r_grant;
            end
        end
    end
endmodule

// File: tb/tb_fifo_drain_rr_arb.sv
// tb_fifo_drain_rr_arb: directed scenarios against behavioural source FIFOs and an output capture queue.
module tb_fifo_drain_rr_arb;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    typedef struct packed {logic [1:0] id; logic last; logic [7:0] d;} beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] mem [N][256];
    int rp [N] = '{default: 0};
    int wp [N] = '{default: 0};
    beat_t cap [$];

    always #5 clk = ~clk;

    fifo_drain_rr_arb_if #(.N_SRC(N), .FIFO_WIDTH(W)) bus ();
    fifo_drain_rr_arb #(.N_SRC(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always_comb begin
        bus.src_empty = '1;
        bus.src_data  = '0;
        for (int i = 0; i < N; i++) begin
            bus.src_empty[i]      = (rp[i] == wp[i]);
            bus.src_data[i*W +: W] = mem[i][rp[i] % 256];
        end
    end

    // Source FIFO pops and output capture; a read of an empty FIFO is a failure.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.src_read_en[i]) begin
                if (rp[i] == wp[i]) begin
                    bad++;
                    $display("FAIL empty_read src=%0d got read_en=1 exp=0", i);
                end
                rp[i] <= rp[i] + 1;
            end
        end
        if (rst_n && bus.out_valid && bus.out_ready)
            cap.push_back({bus.out_src_id, bus.out_last, bus.out_data});
    end

    task automatic push(input int s, input logic [7:0] v);
        mem[s][wp[s] % 256] = v;
        wp[s]++;
    endtask

    task automatic start_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) wp[i] = rp[i];
        cap.delete();
    endtask

    task automatic wait_caps(input int n, input string name);
        int c;
        c = 0;
        while (c < 400 && !(cap.size() >= n && !bus.busy)) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (!(cap.size() >= n && !bus.busy)) begin
            bad++;
            $display("FAIL %s_timeout got words=%0d exp=%0d", name, cap.size(), n);
        end
    endtask

    task automatic test_reset();
        logic ev [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
        logic el [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        int   ed [9] = '{0, 0, 1, 2, 3, 0, 4, 5, 0};
        bus.arb_en = 1'b1;
        bus.out_ready = 1'b1;
        start_reset();
        for (int k = 0; k < 6; k++) push(0, 8'(k));
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.busy, bus.src_read_en} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000000", {bus.out_valid, bus.busy, bus.src_read_en});
        end
        total++;
        if ({bus.out_data, bus.out_src_id, bus.out_last} !== 11'b0) begin
            bad++;
            $display("FAIL reset_out got=%h exp=0", {bus.out_data, bus.out_src_id, bus.out_last});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== ev[c]) begin
                bad++;
                $display("FAIL t1_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, ev[c]);
            end
            if (ev[c]) begin
                total++;
                if ({bus.out_src_id, bus.out_last, bus.out_data} !== {2'd0, el[c], 8'(ed[c])}) begin
                    bad++;
                    $display("FAIL t1_word cyc=%0d got id=%0d last=%b d=%h exp id=0 last=%b d=%h",
                             c, bus.out_src_id, bus.out_last, bus.out_data, el[c], 8'(ed[c]));
                end
            end
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL t1_busy_end got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_fairness();
        beat_t e;
        start_reset();
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 8; k++) push(s, 8'(s*16 + k));
        @(negedge clk);
        rst_n = 1'b1;
        wait_caps(32, "fair");
        total++;
        if (cap.size() != 32) begin
            bad++;
            $display("FAIL fair_count got=%0d exp=32", cap.size());
        end
        for (int n = 0; n < cap.size() && n < 32; n++) begin
            e = {2'((n/4) % 4), (n % 4) == 3, 8'(((n/4) % 4)*16 + (n/16)*4 + n % 4)};
            total++;
            if (cap[n] !== e) begin
                bad++;
                $display("FAIL fair_word n=%0d got=%h exp=%h", n, cap[n], e);
            end
        end
    endtask

    task automatic test_backpressure();
        start_reset();
        for (int k = 0; k < 4; k++) push(1, 8'(8'h10 + k));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.out_src_id, bus.out_data, bus.src_read_en} !== {1'b1, 2'd1, 8'h11, 4'b0}) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b id=%0d d=%h rd=%b exp v=1 id=1 d=11 rd=0000",
                         c, bus.out_valid, bus.out_src_id, bus.out_data, bus.src_read_en);
            end
        end
        bus.out_ready = 1'b1;
        wait_caps(4, "bp");
        total++;
        if (cap.size() != 4) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=4", cap.size());
        end
        for (int n = 0; n < cap.size() && n < 4; n++) begin
            total++;
            if (cap[n] !== {2'd1, n == 3, 8'(8'h10 + n)}) begin
                bad++;
                $display("FAIL bp_word n=%0d got=%h exp=%h", n, cap[n], {2'd1, n == 3, 8'(8'h10 + n)});
            end
        end
    endtask

    task automatic test_skip_wrap();
        beat_t exp_q [4];
        exp_q = '{{2'd0, 1'b0, 8'h00}, {2'd0, 1'b0, 8'h01}, {2'd2, 1'b0, 8'h22}, {2'd2, 1'b0, 8'h23}};
        start_reset();
        push(2, 8'h20);
        push(2, 8'h21);
        @(negedge clk);
        rst_n = 1'b1;
        wait_caps(2, "wrap_pre");
        bus.arb_en = 1'b0;
        cap.delete();
        push(0, 8'h00);
        push(0, 8'h01);
        push(2, 8'h22);
        push(2, 8'h23);
        @(negedge clk);
        bus.arb_en = 1'b1;
        wait_caps(4, "wrap");
        for (int n = 0; n < 4; n++) begin
            total++;
            if (n >= cap.size() || cap[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL wrap_word n=%0d got=%h exp=%h", n, n < cap.size() ? cap[n] : 11'h7ff, exp_q[n]);
            end
        end
    endtask

    task automatic test_arb_en();
        beat_t e;
        start_reset();
        for (int k = 0; k < 8; k++) push(1, 8'(8'h10 + k));
        for (int k = 0; k < 4; k++) push(2, 8'(8'h20 + k));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.arb_en = 1'b0;
        wait_caps(4, "arben_burst");
        repeat (5) @(negedge clk);
        total++;
        if (cap.size() != 4 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL arben_hold got words=%0d busy=%b exp words=4 busy=0", cap.size(), bus.busy);
        end
        bus.arb_en = 1'b1;
        wait_caps(12, "arben");
        for (int n = 0; n < 12; n++) begin
            e = (n >= 4 && n < 8) ? {2'd2, n % 4 == 3, 8'(8'h20 + n - 4)}
              : {2'd1, n % 4 == 3, 8'(8'h10 + (n < 4 ? n : n - 4))};
            total++;
            if (n >= cap.size() || cap[n] !== e) begin
                bad++;
                $display("FAIL arben_word n=%0d got=%h exp=%h", n, n < cap.size() ? cap[n] : 11'h7ff, e);
            end
        end
    endtask

    task automatic test_async_reset();
        beat_t exp_q [4];
        int c;
        exp_q = '{{2'd1, 1'b0, 8'h14}, {2'd1, 1'b0, 8'h15}, {2'd3, 1'b0, 8'h32}, {2'd3, 1'b0, 8'h33}};
        start_reset();
        for (int k = 0; k < 6; k++) push(1, 8'(8'h10 + k));
        for (int k = 0; k < 4; k++) push(3, 8'(8'h30 + k));
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (c < 100 && !(bus.out_valid && bus.out_src_id == 2'd3 && bus.out_data == 8'h31)) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (!(bus.out_valid && bus.out_src_id == 2'd3 && bus.out_data == 8'h31)) begin
            bad++;
            $display("FAIL arst_reach got v=%b id=%0d d=%h exp v=1 id=3 d=31", bus.out_valid, bus.out_src_id, bus.out_data);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.busy, bus.src_read_en} !== 6'b0) begin
            bad++;
            $display("FAIL arst_clear got=%b exp=000000", {bus.out_valid, bus.busy, bus.src_read_en});
        end
        @(negedge clk);
        cap.delete();
        rst_n = 1'b1;
        wait_caps(4, "arst");
        for (int n = 0; n < 4; n++) begin
            total++;
            if (n >= cap.size() || cap[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL arst_word n=%0d got=%h exp=%h", n, n < cap.size() ? cap[n] : 11'h7ff, exp_q[n]);
            end
        end
    endtask

    initial begin
        bus.arb_en = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        test_reset();
        test_fairness();
        test_backpressure();
        test_skip_wrap();
        test_arb_en();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
